hssl_link_controller: RTL
=========================

HSSL_LINK_CONTROLLER -- requirements
Module: hssl_link_controller

Interface
REQ-001 SHALL have parameters, one per line:
- RST_CYCLES, 16: transceiver/interface reset hold length.
- STABLE_CYCLES, 64: consecutive in-sync cycles required before handshake.
- TIMEOUT_CYCLES, 1048576: per-phase timeout.
- BACKOFF_CYCLES, 1024: wait between retries.
- MAX_RETRIES, 8: consecutive failed attempts before FAIL.
- WDOG_CYCLES, 65536: rx inactivity limit in UP.

REQ-002 SHALL have ports, one per line:
- clk, in, 1: single clock for all logic.
- reset, in, 1: synchronous, active-low reset.
- enable_in, in, 1: link enable.
- loss_of_sync_state_in, in, 2: 00 = sync acquired, 01 = resync, 10 = loss.
- handshake_complete_in, in, 1: link handshake done.
- version_mismatch_in, in, 1: peer version mismatch.
- rx_activity_in, in, 1: received-frame valid strobe.
- gt_reset_out, out, 1: transceiver reset, active-high.
- hssl_reset_out, out, 1: serial-link interface reset, active-high.
- stop_out, out, 1: frame-transmitter stop.
- link_up_out, out, 1: link usable.
- state_out, out, 3: current state encoding.
- retry_cnt_out, out, 4: consecutive retries, saturating.
- error_out, out, 1: sticky failure flag.

Function
REQ-003 SHALL implement the states IDLE=0, GT_RST=1, WAIT_SYNC=2, WAIT_HSHK=3, UP=4, BACKOFF=5, FAIL=6, with state_out equal to the encoding.

REQ-004 SHALL move to IDLE on the next clock edge from any state when enable_in=0; this has highest priority.

REQ-005 IDLE: gt_reset_out=1, hssl_reset_out=1, stop_out=1, retry_cnt_out cleared, error_out cleared; when enable_in=1, move to GT_RST.

REQ-006 GT_RST: gt_reset_out=1, hssl_reset_out=1 for exactly RST_CYCLES cycles, then move to WAIT_SYNC.

REQ-007 WAIT_SYNC: gt_reset_out=0, hssl_reset_out=1; move to WAIT_HSHK after STABLE_CYCLES consecutive cycles with loss_of_sync_state_in=00; any non-00 value restarts the stability count.

REQ-008 WAIT_HSHK: hssl_reset_out=0, stop_out=1; transitions, in priority order:
- version_mismatch_in=1 -> FAIL.
- loss_of_sync_state_in!=00 -> BACKOFF.
- handshake_complete_in=1 -> UP.

REQ-009 SHALL move WAIT_SYNC or WAIT_HSHK to BACKOFF once TIMEOUT_CYCLES cycles have elapsed in that state without exit.

REQ-010 UP: link_up_out=1, stop_out=0, retry_cnt_out cleared on entry; move to BACKOFF when loss_of_sync_state_in!=00 or handshake_complete_in=0.

REQ-011 BACKOFF: gt_reset_out=0, hssl_reset_out=1, stop_out=1; retry_cnt_out increments once on entry, saturating at 15; after BACKOFF_CYCLES cycles:
- retry_cnt_out>=MAX_RETRIES -> FAIL.
- otherwise -> GT_RST.

REQ-012 FAIL: error_out=1 (sticky), hssl_reset_out=1, stop_out=1; FAIL is left only via enable_in=0.

REQ-013 link_up_out SHALL be 1 only in UP; all outputs SHALL be registered (one-cycle latency from a state change).

REQ-014 A single phase counter SHALL be reloaded on every state entry; it SHALL be wide enough for the largest parameter and SHALL never wrap.

Reset
REQ-015 While reset=0 at a clock edge: state=IDLE, gt_reset_out=1, hssl_reset_out=1, stop_out=1, link_up_out=0, retry_cnt_out=0, error_out=0, counters cleared.

REQ-016 Reset asserted mid-operation, including in UP or FAIL, SHALL return the block to IDLE on that edge.

Configuration
REQ-017 With macro HSSL_LINK_WDOG_EN defined: in UP, WDOG_CYCLES consecutive cycles with rx_activity_in=0 SHALL cause a move to BACKOFF, and each rx_activity_in=1 restarts the count.

REQ-018 Without HSSL_LINK_WDOG_EN: rx_activity_in is ignored, the WDOG_CYCLES parameter has no effect, and no watchdog logic is synthesised.

Structure
REQ-019 Package hssl_link_pkg SHALL hold the state enum/encoding, the default parameter constants, and the retry-counter width.

REQ-020 The shared phase down-counter SHALL be a sub-module hssl_link_timer (load, value, done); the FSM stays in hssl_link_controller.

Verification
REQ-021 The bench SHALL cover these directed scenarios (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=100, BACKOFF_CYCLES=10, MAX_RETRIES=3):
- Bring-up: enable=1, sync=00 held, handshake at cycle 20 -> gt_reset high 4 cycles, WAIT_HSHK after 8 stable cycles, link_up=1, stop=0.
- Sync glitch: sync=01 for one cycle at stable count 7 -> stability restarts, WAIT_HSHK 8 cycles later.
- Retries: sync never 00 -> three timeouts, retry_cnt 1, 2, 3, then FAIL, error=1; enable=0 -> IDLE, error=0.
- Mismatch: version_mismatch=1 in WAIT_HSHK -> FAIL on next edge, no retry.
- Link drop: in UP, sync=10 -> link_up=0, BACKOFF, retry_cnt=1, re-bring-up clears retry_cnt to 0.
- Watchdog (macro defined, WDOG_CYCLES=50): no rx_activity for 50 cycles in UP -> BACKOFF; macro undefined -> remains UP.

Source files
------------

// File: rtl/hssl_link_pkg.sv
// Shared definitions for the HSSL link controller: state encoding, default
// timing constants, retry-counter width and counter-width helpers.
// Optional feature macro used by the controller: HSSL_LINK_WDOG_EN.
package hssl_link_pkg;

    // FSM state encoding (also driven on state_out)
    localparam int unsigned STATE_W = 3;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GT_RST    = 3'd1;
    localparam logic [2:0] ST_WAIT_SYNC = 3'd2;
    localparam logic [2:0] ST_WAIT_HSHK = 3'd3;
    localparam logic [2:0] ST_UP        = 3'd4;
    localparam logic [2:0] ST_BACKOFF   = 3'd5;
    localparam logic [2:0] ST_FAIL      = 3'd6;

    // Default timing constants
    localparam int unsigned DEF_RST_CYCLES     = 16;
    localparam int unsigned DEF_STABLE_CYCLES  = 64;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1048576;
    localparam int unsigned DEF_BACKOFF_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRIES    = 8;
    localparam int unsigned DEF_WDOG_CYCLES    = 65536;

    // Retry counter width and saturation value
    localparam int unsigned          RETRY_W   = 4;
    localparam logic [RETRY_W-1:0]   RETRY_SAT = 4'd15;

    // Sync status encoding of loss_of_sync_state_in
    localparam logic [1:0] SYNC_OK = 2'b00;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..n (at least 1)
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hssl_link_timer.sv
// Phase down-counter shared by all FSM states.
// Ports:
//   clk    - clock
//   reset  - synchronous active-low reset
//   load   - reload counter with value (takes priority over counting)
//   value  - reload value (cycles remaining minus one)
//   done   - registered, high while the counter holds zero
// The counter stops at zero and never wraps.
module hssl_link_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: reload, else decrement until zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register; done tracks the registered count
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            done  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            done  <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/hssl_link_controller.sv
// HSSL link bring-up controller: resets the transceiver, waits for stable
// sync, runs the handshake, supervises the link and retries with backoff.
// Optional rx-inactivity watchdog in UP enabled by macro HSSL_LINK_WDOG_EN.
// Ports:
//   clk                    - clock
//   reset                  - synchronous active-low reset
//   enable_in              - link enable (low forces IDLE)
//   loss_of_sync_state_in  - 00 sync, 01 resync, 10 loss
//   handshake_complete_in  - handshake done
//   version_mismatch_in    - peer version mismatch
//   rx_activity_in         - received-frame valid strobe (watchdog only)
//   gt_reset_out           - transceiver reset
//   hssl_reset_out         - serial-link interface reset
//   stop_out               - frame-transmitter stop
//   link_up_out            - link usable (UP only)
//   state_out              - current state encoding
//   retry_cnt_out          - consecutive retries, saturating
//   error_out              - sticky failure flag
module hssl_link_controller
    import hssl_link_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned BACKOFF_CYCLES = DEF_BACKOFF_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int unsigned WDOG_CYCLES    = DEF_WDOG_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_in,
    input  logic [1:0]         loss_of_sync_state_in,
    input  logic               handshake_complete_in,
    input  logic               version_mismatch_in,
    input  logic               rx_activity_in,
    output logic               gt_reset_out,
    output logic               hssl_reset_out,
    output logic               stop_out,
    output logic               link_up_out,
    output logic [STATE_W-1:0] state_out,
    output logic [RETRY_W-1:0] retry_cnt_out,
    output logic               error_out
);

`ifdef HSSL_LINK_WDOG_EN
    localparam int unsigned MAX_CYCLES = max2(max2(max2(RST_CYCLES, STABLE_CYCLES),
                                                   max2(TIMEOUT_CYCLES, BACKOFF_CYCLES)),
                                              WDOG_CYCLES);
`else
    localparam int unsigned MAX_CYCLES = max2(max2(RST_CYCLES, STABLE_CYCLES),
                                              max2(TIMEOUT_CYCLES, BACKOFF_CYCLES));
`endif
    localparam int unsigned TW = cnt_width(MAX_CYCLES);
    localparam int unsigned SW = cnt_width(STABLE_CYCLES);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [SW-1:0]      stable_q;
    logic [SW-1:0]      stable_d;
    logic [RETRY_W-1:0] retry_d;
    logic               error_d;
    logic               gt_reset_d;
    logic               hssl_reset_d;
    logic               stop_d;
    logic               link_up_d;
    logic               entering_c;
    logic               tmr_load_c;
    logic [TW-1:0]      tmr_value_c;
    logic               tmr_done;
    logic               sync_ok_c;

    assign sync_ok_c = (loss_of_sync_state_in == SYNC_OK);

`ifndef HSSL_LINK_WDOG_EN
    // Watchdog inputs are intentionally ignored in this build
    logic unused_wdog;
    assign unused_wdog = ^{rx_activity_in, 32'(WDOG_CYCLES)};
`endif

    // Shared phase timer, reloaded on every state entry
    hssl_link_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load_c),
        .value (tmr_value_c),
        .done  (tmr_done)
    );

    // Next-state, entry actions and next output values
    always_comb begin
        state_d      = state_q;
        stable_d     = '0;
        retry_d      = retry_cnt_out;
        error_d      = error_out;
        gt_reset_d   = 1'b0;
        hssl_reset_d = 1'b1;
        stop_d       = 1'b1;
        link_up_d    = 1'b0;
        tmr_value_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable_in) state_d = ST_GT_RST;
            end
            ST_GT_RST: begin
                if (tmr_done) state_d = ST_WAIT_SYNC;
            end
            ST_WAIT_SYNC: begin
                // Any non-00 sync value restarts the stability count
                if (sync_ok_c && (stable_q == STABLE_LAST)) begin
                    state_d = ST_WAIT_HSHK;
                end else if (tmr_done) begin
                    state_d = ST_BACKOFF;
                end else if (sync_ok_c) begin
                    stable_d = stable_q + SW'(1);
                end
            end
            ST_WAIT_HSHK: begin
                if (version_mismatch_in)        state_d = ST_FAIL;
                else if (!sync_ok_c)            state_d = ST_BACKOFF;
                else if (handshake_complete_in) state_d = ST_UP;
                else if (tmr_done)              state_d = ST_BACKOFF;
            end
            ST_UP: begin
                if (!sync_ok_c || !handshake_complete_in) state_d = ST_BACKOFF;
`ifdef HSSL_LINK_WDOG_EN
                else if (tmr_done)                        state_d = ST_BACKOFF;
`endif
            end
            ST_BACKOFF: begin
                if (tmr_done) begin
                    state_d = (32'(retry_cnt_out) >= MAX_RETRIES) ? ST_FAIL : ST_GT_RST;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!enable_in) state_d = ST_IDLE;
        if (state_d != ST_WAIT_SYNC) stable_d = '0;

        entering_c = (state_d != state_q);

        // Retry/error bookkeeping on entry
        if (state_d == ST_IDLE) begin
            retry_d = '0;
            error_d = 1'b0;
        end
        if (entering_c && (state_d == ST_BACKOFF) && (retry_cnt_out != RETRY_SAT)) begin
            retry_d = retry_cnt_out + RETRY_W'(1);
        end
        if (entering_c && (state_d == ST_UP)) retry_d = '0;
        if (state_d == ST_FAIL) error_d = 1'b1;

`ifdef HSSL_LINK_WDOG_EN
        // Each rx strobe in UP restarts the inactivity window
        tmr_load_c = entering_c || ((state_q == ST_UP) && rx_activity_in);
`else
        tmr_load_c = entering_c;
`endif

        // Timer reload value and outputs for the state being entered
        case (state_d)
            ST_IDLE: begin
                gt_reset_d = 1'b1;
            end
            ST_GT_RST: begin
                gt_reset_d  = 1'b1;
                tmr_value_c = TW'(RST_CYCLES - 1);
            end
            ST_WAIT_SYNC: begin
                tmr_value_c = TW'(TIMEOUT_CYCLES - 1);
            end
            ST_WAIT_HSHK: begin
                hssl_reset_d = 1'b0;
                tmr_value_c  = TW'(TIMEOUT_CYCLES - 1);
            end
            ST_UP: begin
                hssl_reset_d = 1'b0;
                stop_d       = 1'b0;
                link_up_d    = 1'b1;
`ifdef HSSL_LINK_WDOG_EN
                tmr_value_c  = TW'(WDOG_CYCLES - 1);
`endif
            end
            ST_BACKOFF: begin
                tmr_value_c = TW'(BACKOFF_CYCLES - 1);
            end
            default: begin
                gt_reset_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            stable_q       <= '0;
            state_out      <= ST_IDLE;
            retry_cnt_out  <= '0;
            error_out      <= 1'b0;
            gt_reset_out   <= 1'b1;
            hssl_reset_out <= 1'b1;
            stop_out       <= 1'b1;
            link_up_out    <= 1'b0;
        end else begin
            state_q        <= state_d;
            stable_q       <= stable_d;
            state_out      <= state_d;
            retry_cnt_out  <= retry_d;
            error_out      <= error_d;
            gt_reset_out   <= gt_reset_d;
            hssl_reset_out <= hssl_reset_d;
            stop_out       <= stop_d;
            link_up_out    <= link_up_d;
        end
    end

endmodule
